pipe_control_unit: RTL and testbench

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

---
 rtl/pipe_control_unit_if.sv | 37 +++
 rtl/pipe_control_unit.sv | 168 ++++++++++++++++
 tb/tb_pipe_control_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_control_unit_if.sv
// rtl/pipe_control_unit_if.sv - IF/ID inputs and stage-control outputs of the pipeline control unit
interface pipe_control_unit_if #(
  parameter int REG_AW = 3
);
  logic [3:0]        opcode;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;

  logic              ex_ALU_src;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic              mem_MR;
  logic              mem_MW;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_MReg;
  logic              wb_EnRW;
  logic [REG_AW-1:0] wb_rd;
  logic              PCWrite;
  logic              IFIDWrite;
  logic              ST;
  logic [1:0]        FA;
  logic [1:0]        FB;
  logic              illegal;

  modport master (
    output opcode, id_rs1, id_rs2, id_rd,
    input  ex_ALU_src, ex_rs1, ex_rs2, mem_MR, mem_MW, mem_rd,
    input  wb_MReg, wb_EnRW, wb_rd, PCWrite, IFIDWrite, ST, FA, FB, illegal
  );

  modport slave (
    input  opcode, id_rs1, id_rs2, id_rd,
    output ex_ALU_src, ex_rs1, ex_rs2, mem_MR, mem_MW, mem_rd,
    output wb_MReg, wb_EnRW, wb_rd, PCWrite, IFIDWrite, ST, FA, FB, illegal
  );
endinterface

// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - decode, ID/EX/MEM/WB control pipeline, load-use stall and forwarding selects
module pipe_control_unit #(
  parameter int REG_AW       = 3,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_control_unit_if.slave bus
);

  typedef struct packed {
    logic alu_src;
    logic mr;
    logic mw;
    logic mreg;
    logic enrw;
  } ctl_t;

  localparam ctl_t BUBBLE_CTL = 5'b00010;

  ctl_t              dec_ctl;
  logic              dec_legal;
  logic              dec_use_rs2;

  ctl_t              ex_ctl;
  logic [REG_AW-1:0] ex_rd;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic              ex_use_rs2;
  logic              ex_illegal;

  logic              mem_mr;
  logic              mem_mw;
  logic              mem_mreg;
  logic              mem_enrw;
  logic [REG_AW-1:0] mem_rd;

  logic              wb_mreg;
  logic              wb_enrw;
  logic [REG_AW-1:0] wb_rd;

  logic              st;
  logic [1:0]        fa;
  logic [1:0]        fb;
  logic              ex_rd_live;
  logic              mem_rd_live;
  logic              wb_rd_live;

  always_comb begin
    dec_ctl     = BUBBLE_CTL;
    dec_legal   = 1'b1;
    dec_use_rs2 = 1'b0;
    case (bus.opcode)
      4'b0000: begin
        dec_ctl     = 5'b00011;
        dec_use_rs2 = 1'b1;
      end
      4'b0001: begin
        dec_ctl     = 5'b10110;
        dec_use_rs2 = 1'b1;
      end
      4'b0010: dec_ctl = 5'b11001;
      4'b0011: dec_ctl = 5'b10011;
      4'b0111: begin
        dec_ctl     = 5'b00011;
        dec_use_rs2 = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // With r0 hardwired, a zero destination never produces a usable value.
  assign ex_rd_live  = R0_HARDWIRED ? (ex_rd  != '0) : 1'b1;
  assign mem_rd_live = R0_HARDWIRED ? (mem_rd != '0) : 1'b1;
  assign wb_rd_live  = R0_HARDWIRED ? (wb_rd  != '0) : 1'b1;

  // Only defined opcodes read rs1, so an undefined opcode can never stall.
  always_comb begin
    st = 1'b0;
    if (ex_ctl.mr && ex_ctl.enrw && ex_rd_live) begin
      if ((dec_legal && ex_rd == bus.id_rs1) || (dec_use_rs2 && ex_rd == bus.id_rs2)) begin
        st = 1'b1;
      end
    end
  end

  // EX/MEM is checked first so the youngest producer wins.
  always_comb begin
    fa = 2'b00;
    if (mem_enrw && !mem_mr && mem_rd_live && mem_rd == ex_rs1) begin
      fa = 2'b10;
    end else if (wb_enrw && wb_rd_live && wb_rd == ex_rs1) begin
      fa = 2'b01;
    end
    fb = 2'b00;
    if (ex_use_rs2) begin
      if (mem_enrw && !mem_mr && mem_rd_live && mem_rd == ex_rs2) begin
        fb = 2'b10;
      end else if (wb_enrw && wb_rd_live && wb_rd == ex_rs2) begin
        fb = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctl     <= BUBBLE_CTL;
      ex_rd      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_use_rs2 <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (st || !dec_legal) begin
      ex_ctl     <= BUBBLE_CTL;
      ex_rd      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_use_rs2 <= 1'b0;
      ex_illegal <= !st && !dec_legal;
    end else begin
      ex_ctl     <= dec_ctl;
      ex_rd      <= bus.id_rd;
      ex_rs1     <= bus.id_rs1;
      ex_rs2     <= bus.id_rs2;
      ex_use_rs2 <= dec_use_rs2;
      ex_illegal <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_mr   <= 1'b0;
      mem_mw   <= 1'b0;
      mem_mreg <= 1'b1;
      mem_enrw <= 1'b0;
      mem_rd   <= '0;
      wb_mreg  <= 1'b1;
      wb_enrw  <= 1'b0;
      wb_rd    <= '0;
    end else begin
      mem_mr   <= ex_ctl.mr;
      mem_mw   <= ex_ctl.mw;
      mem_mreg <= ex_ctl.mreg;
      mem_enrw <= ex_ctl.enrw;
      mem_rd   <= ex_rd;
      wb_mreg  <= mem_mreg;
      wb_enrw  <= mem_enrw;
      wb_rd    <= mem_rd;
    end
  end

  assign bus.ex_ALU_src = ex_ctl.alu_src;
  assign bus.ex_rs1     = ex_rs1;
  assign bus.ex_rs2     = ex_rs2;
  assign bus.illegal    = ex_illegal;
  assign bus.mem_MR     = mem_mr;
  assign bus.mem_MW     = mem_mw;
  assign bus.mem_rd     = mem_rd;
  assign bus.wb_MReg    = wb_mreg;
  assign bus.wb_EnRW    = wb_enrw;
  assign bus.wb_rd      = wb_rd;
  assign bus.ST         = st;
  assign bus.PCWrite    = ~st;
  assign bus.IFIDWrite  = ~st;
  assign bus.FA         = fa;
  assign bus.FB         = fb;

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - random and directed checks of pipe_control_unit against an instruction-level model
module tb_pipe_control_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipe_control_unit_if #(.REG_AW(3)) bus ();

  pipe_control_unit #(.REG_AW(3), .R0_HARDWIRED(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each stage holds the instruction word that entered it, or a bubble.
  typedef struct packed {
    logic       bub;
    logic [3:0] op;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
  } instr_t;

  localparam instr_t BUB = {1'b1, 13'b0};

  instr_t m [3];

  function automatic logic defd(logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd7);
  endfunction

  function automatic logic is_real(instr_t i);
    return !i.bub && defd(i.op);
  endfunction

  // {ALU_src, MR, MW, MReg, EnRW}
  function automatic logic [4:0] ctl(instr_t i);
    if (!is_real(i)) return 5'b00010;
    case (i.op)
      4'd0:    return 5'b00011;
      4'd1:    return 5'b10110;
      4'd2:    return 5'b11001;
      4'd3:    return 5'b10011;
      default: return 5'b00011;
    endcase
  endfunction

  function automatic logic uses_rs2(instr_t i);
    return is_real(i) && (i.op == 4'd0 || i.op == 4'd1 || i.op == 4'd7);
  endfunction

  function automatic logic [2:0] f_rd(instr_t i);
    return is_real(i) ? i.rd : 3'd0;
  endfunction

  function automatic logic [2:0] f_rs1(instr_t i);
    return is_real(i) ? i.rs1 : 3'd0;
  endfunction

  function automatic logic [2:0] f_rs2(instr_t i);
    return is_real(i) ? i.rs2 : 3'd0;
  endfunction

  function automatic instr_t id_instr();
    return {1'b0, bus.opcode, bus.id_rs1, bus.id_rs2, bus.id_rd};
  endfunction

  function automatic logic m_st();
    instr_t     e;
    instr_t     d;
    logic [4:0] c;
    e = m[0];
    d = id_instr();
    c = ctl(e);
    if (!(c[3] && c[0] && f_rd(e) != 3'd0)) return 1'b0;
    return (is_real(d) && f_rd(e) == d.rs1) || (uses_rs2(d) && f_rd(e) == d.rs2);
  endfunction

  function automatic logic [1:0] m_fwd(logic [2:0] src);
    logic [4:0] cm;
    logic [4:0] cw;
    cm = ctl(m[1]);
    cw = ctl(m[2]);
    if (cm[0] && !cm[3] && f_rd(m[1]) != 3'd0 && f_rd(m[1]) == src) return 2'b10;
    if (cw[0] && f_rd(m[2]) != 3'd0 && f_rd(m[2]) == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= BUB;
      m[1] <= BUB;
      m[2] <= BUB;
    end else begin
      m[2] <= m[1];
      m[1] <= m[0];
      m[0] <= m_st() ? BUB : id_instr();
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [4:0] ce;
    logic [4:0] cm;
    logic [4:0] cw;
    logic       st_e;
    ce   = ctl(m[0]);
    cm   = ctl(m[1]);
    cw   = ctl(m[2]);
    st_e = m_st();
    chk("m_ex_ALU_src", 8'(bus.ex_ALU_src), 8'(ce[4]));
    chk("m_ex_rs1",     8'(bus.ex_rs1),     8'(f_rs1(m[0])));
    chk("m_ex_rs2",     8'(bus.ex_rs2),     8'(f_rs2(m[0])));
    chk("m_illegal",    8'(bus.illegal),    8'(!m[0].bub && !defd(m[0].op)));
    chk("m_mem_MR",     8'(bus.mem_MR),     8'(cm[3]));
    chk("m_mem_MW",     8'(bus.mem_MW),     8'(cm[2]));
    chk("m_mem_rd",     8'(bus.mem_rd),     8'(f_rd(m[1])));
    chk("m_wb_MReg",    8'(bus.wb_MReg),    8'(cw[1]));
    chk("m_wb_EnRW",    8'(bus.wb_EnRW),    8'(cw[0]));
    chk("m_wb_rd",      8'(bus.wb_rd),      8'(f_rd(m[2])));
    chk("m_ST",         8'(bus.ST),         8'(st_e));
    chk("m_PCWrite",    8'(bus.PCWrite),    8'(!st_e));
    chk("m_IFIDWrite",  8'(bus.IFIDWrite),  8'(!st_e));
    chk("m_FA",         8'(bus.FA),         8'(m_fwd(f_rs1(m[0]))));
    chk("m_FB",         8'(bus.FB),         8'(uses_rs2(m[0]) ? m_fwd(f_rs2(m[0])) : 2'b00));
  end

  task automatic set_in(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [2:0] rd);
    bus.opcode = op;
    bus.id_rs1 = rs1;
    bus.id_rs2 = rs2;
    bus.id_rd  = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_ex_ALU_src"}, 8'(bus.ex_ALU_src), 8'd0);
    chk({tag, "_mem_MR"},     8'(bus.mem_MR),     8'd0);
    chk({tag, "_mem_MW"},     8'(bus.mem_MW),     8'd0);
    chk({tag, "_wb_MReg"},    8'(bus.wb_MReg),    8'd1);
    chk({tag, "_wb_EnRW"},    8'(bus.wb_EnRW),    8'd0);
    chk({tag, "_fields"},     {2'b0, bus.ex_rs1, bus.ex_rs2}, 8'd0);
    chk({tag, "_rds"},        {2'b0, bus.mem_rd, bus.wb_rd},  8'd0);
    chk({tag, "_illegal"},    8'(bus.illegal),    8'd0);
    chk({tag, "_ST"},         8'(bus.ST),         8'd0);
    chk({tag, "_PCWrite"},    8'(bus.PCWrite),    8'd1);
    chk({tag, "_IFIDWrite"},  8'(bus.IFIDWrite),  8'd1);
    chk({tag, "_FA_FB"},      {4'b0, bus.FA, bus.FB}, 8'd0);
  endtask

  function automatic logic [3:0] rand_op();
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      0, 1:    return 4'd2;
      2:       return 4'd0;
      3:       return 4'd1;
      4:       return 4'd3;
      5, 6:    return 4'd7;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    logic hold;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_in(4'd0, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    reset_values("rst0");
    #2 rst_n = 1'b1;
    tick();

    // Load r3 then a consumer of r3: one stall, bubble, then forward from MEM/WB.
    set_in(4'd2, 3'd0, 3'd0, 3'd3);
    tick();
    set_in(4'd7, 3'd3, 3'd5, 3'd4);
    @(negedge clk);
    chk("lu_ST_1", 8'(bus.ST), 8'd1);
    chk("lu_PCWrite_0", 8'(bus.PCWrite), 8'd0);
    chk("lu_IFIDWrite_0", 8'(bus.IFIDWrite), 8'd0);
    tick();
    @(negedge clk);
    chk("lu_ST_fall", 8'(bus.ST), 8'd0);
    chk("lu_PCWrite_1", 8'(bus.PCWrite), 8'd1);
    chk("lu_bubble_rs1", 8'(bus.ex_rs1), 8'd0);
    chk("lu_load_in_mem", 8'(bus.mem_MR), 8'd1);
    tick();
    @(negedge clk);
    chk("lu_FA_01", 8'(bus.FA), 8'd1);
    chk("lu_consumer_rs1", 8'(bus.ex_rs1), 8'd3);

    // Two producers of r2: EX/MEM wins over MEM/WB on both operands.
    set_in(4'd0, 3'd1, 3'd1, 3'd2);
    tick();
    set_in(4'd0, 3'd1, 3'd1, 3'd2);
    tick();
    set_in(4'd7, 3'd2, 3'd2, 3'd6);
    tick();
    @(negedge clk);
    chk("prio_FA_10", 8'(bus.FA), 8'd2);
    chk("prio_FB_10", 8'(bus.FB), 8'd2);

    // Load to r0 never stalls or forwards.
    set_in(4'd2, 3'd0, 3'd0, 3'd0);
    tick();
    set_in(4'd7, 3'd0, 3'd0, 3'd1);
    @(negedge clk);
    chk("r0_ST_0", 8'(bus.ST), 8'd0);
    tick();
    @(negedge clk);
    chk("r0_FA_00", 8'(bus.FA), 8'd0);

    // ALU-imm does not read rs2.
    set_in(4'd0, 3'd1, 3'd1, 3'd5);
    tick();
    set_in(4'd3, 3'd5, 3'd5, 3'd6);
    tick();
    @(negedge clk);
    chk("imm_FB_00", 8'(bus.FB), 8'd0);
    chk("imm_FA_10", 8'(bus.FA), 8'd2);
    set_in(4'd2, 3'd0, 3'd0, 3'd5);
    tick();
    set_in(4'd3, 3'd1, 3'd5, 3'd6);
    @(negedge clk);
    chk("imm_ST_0", 8'(bus.ST), 8'd0);
    tick();

    // Undefined opcode behind a load of its rs1 field.
    set_in(4'd2, 3'd0, 3'd0, 3'd1);
    tick();
    set_in(4'd10, 3'd1, 3'd1, 3'd3);
    @(negedge clk);
    chk("ill_ST_0", 8'(bus.ST), 8'd0);
    tick();
    @(negedge clk);
    chk("ill_illegal_1", 8'(bus.illegal), 8'd1);
    chk("ill_ALU_src_0", 8'(bus.ex_ALU_src), 8'd0);
    chk("ill_MW_a", 8'(bus.mem_MW), 8'd0);
    set_in(4'd3, 3'd2, 3'd2, 3'd4);
    tick();
    @(negedge clk);
    chk("ill_MW_b", 8'(bus.mem_MW), 8'd0);
    chk("ill_mem_rd_0", 8'(bus.mem_rd), 8'd0);
    tick();
    @(negedge clk);
    chk("ill_wb_EnRW_0", 8'(bus.wb_EnRW), 8'd0);
    chk("ill_wb_rd_0", 8'(bus.wb_rd), 8'd0);
    chk("ill_MW_c", 8'(bus.mem_MW), 8'd0);
    tick();

    // Asynchronous reset in the middle of a stall.
    set_in(4'd2, 3'd0, 3'd0, 3'd4);
    tick();
    set_in(4'd7, 3'd4, 3'd0, 3'd1);
    @(negedge clk);
    chk("ar_ST_before", 8'(bus.ST), 8'd1);
    #2 rst_n = 1'b0;
    #1 reset_values("arst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    hold = m_st();
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        set_in(rand_op(), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)));
      end
      hold = m_st();
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
